store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/sb_pkg.sv | 16 +
 rtl/sb_fifo.sv | 102 ++++++++++
 rtl/store_buffer.sv | 130 +++++++++++++
 tb/tb_store_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared defaults, pointer width and entry type for the store buffer.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 16;
  localparam int SB_DW    = 16;
  localparam int SB_PW    = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef logic [SB_PW-1:0] sb_ptr_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular queue of buffered stores: per-slot addr/data registers plus head/tail/count.
// With STORE_BUFFER_FORWARD_EN every slot is also presented in age order (0 = oldest).
module sb_fifo
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty
`ifdef STORE_BUFFER_FORWARD_EN
  ,
  output logic [AW-1:0]    age_addr [DEPTH],
  output logic [DW-1:0]    age_data [DEPTH],
  output logic [DEPTH-1:0] age_valid
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [AW-1:0] slot_addr [DEPTH];
  logic [DW-1:0] slot_data [DEPTH];

  // Pointers are PW bits wide and DEPTH is a power of two, so increment wraps naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    localparam logic [PW-1:0] SLOT = PW'(gi);
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      if (push && tail_q == SLOT) begin
        addr_d = push_addr;
        data_d = push_data;
      end
    end

    // Slot contents need no reset: validity is carried entirely by head/count.
    always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
    end

    assign slot_addr[gi] = addr_q;
    assign slot_data[gi] = data_q;
  end

  assign head_addr = slot_addr[head_q];
  assign head_data = slot_data[head_q];
  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);

`ifdef STORE_BUFFER_FORWARD_EN
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    localparam logic [PW-1:0] OFFSET = PW'(gi);
    localparam logic [PW:0]   AGE    = (PW+1)'(gi);
    logic [PW-1:0] slot;

    assign slot          = head_q + OFFSET;
    assign age_addr[gi]  = slot_addr[slot];
    assign age_data[gi]  = slot_data[slot];
    assign age_valid[gi] = (AGE < count_q);
  end
`endif

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues CPU stores and drains them to data memory whenever the port is free.
// Define STORE_BUFFER_FORWARD_EN to give loads priority with store-to-load forwarding.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  output logic          mem_WE,
  output logic          mem_RE,
  input  logic [DW-1:0] mem_RD
);

  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          full;
  logic          empty;
  logic          push;
  logic          drain;
  logic          load_grant;
  logic          load_stall;
  logic          store_stall;

`ifdef STORE_BUFFER_FORWARD_EN
  logic [AW-1:0]    age_addr [DEPTH];
  logic [DW-1:0]    age_data [DEPTH];
  logic [DEPTH-1:0] age_valid;
  logic [DEPTH-1:0] age_hit;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;
`endif

  sb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .srst      (rst),
    .push      (push),
    .push_addr (cpu_addr),
    .push_data (cpu_wdata),
    .pop       (drain),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
`ifdef STORE_BUFFER_FORWARD_EN
    ,
    .age_addr  (age_addr),
    .age_data  (age_data),
    .age_valid (age_valid)
`endif
  );

  // Port arbitration; a full buffer still accepts a store when the head drains this cycle.
  always_comb begin
    load_grant  = 1'b0;
    load_stall  = 1'b0;
    drain       = 1'b0;
    store_stall = 1'b0;
    if (!rst) begin
`ifdef STORE_BUFFER_FORWARD_EN
      load_grant = cpu_re;
`else
      load_grant = cpu_re && empty;
      load_stall = cpu_re && !empty;
`endif
      drain       = !empty && !load_grant;
      store_stall = cpu_we && full && !drain;
    end
    push      = cpu_we && !store_stall && !rst;
    cpu_stall = store_stall || load_stall;
  end

  always_comb begin
    mem_A  = '0;
    mem_WD = '0;
    mem_WE = 1'b0;
    mem_RE = 1'b0;
    if (drain) begin
      mem_A  = head_addr;
      mem_WD = head_data;
      mem_WE = 1'b1;
    end else if (load_grant) begin
      mem_A  = cpu_addr;
      mem_RE = 1'b1;
    end
  end

`ifdef STORE_BUFFER_FORWARD_EN
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign age_hit[gi] = age_valid[gi] && (age_addr[gi] == cpu_addr);
  end

  // Scan oldest to youngest so the youngest matching store wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_hit[k]) begin
        fwd_hit  = 1'b1;
        fwd_data = age_data[k];
      end
    end
  end

  always_comb begin
    cpu_rdata = '0;
    if (cpu_re) cpu_rdata = fwd_hit ? fwd_data : mem_RD;
  end
`else
  always_comb begin
    cpu_rdata = '0;
    if (load_grant) cpu_rdata = mem_RD;
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: vector table, directed corner sequences and a
// write scoreboard fed on store acceptance and drained on memory writes.
module tb_store_buffer;
  import sb_pkg::*;

  localparam int DEPTH = SB_DEPTH;
  localparam int AW    = SB_AW;
  localparam int DW    = SB_DW;
`ifdef STORE_BUFFER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_we = 1'b0;
  logic          cpu_re = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_WD;
  logic          mem_WE;
  logic          mem_RE;
  logic [DW-1:0] mem_RD;

  logic [DW-1:0] tb_mem [0:(1<<AW)-1];
  sb_entry_t     sb_q [$];
  int            n_pass = 0;
  int            n_total = 0;

  always #5 clk = ~clk;
  assign mem_RD = tb_mem[mem_A];

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RE(mem_RE), .mem_RD(mem_RD)
  );

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return DW'(a) ^ DW'(16'h5A5A);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic we, input logic re,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    rst = r; cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    #1;
  endtask

  task automatic drain_all(input string tag);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_count"}, 32'(dut.u_fifo.count_q), 32'd0);
  endtask

  // Memory model and write scoreboard; one line per memory write.
  initial begin
    sb_entry_t exp_e;
    for (int i = 0; i < (1 << AW); i++) tb_mem[i] = pattern(AW'(i));
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
      end else begin
        if (mem_WE) begin
          if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL stray_write: got write 0x%0h<-0x%0h, expected no write", mem_A, mem_WD);
          end else begin
            exp_e = sb_q.pop_front();
            $display("write 0x%0h<-0x%0h", mem_A, mem_WD);
            check("drain_addr", 32'(mem_A), 32'(exp_e.addr));
            check("drain_data", 32'(mem_WD), 32'(exp_e.data));
          end
          tb_mem[mem_A] = mem_WD;
        end
        if (cpu_we && !cpu_stall) sb_q.push_back('{addr: cpu_addr, data: cpu_wdata});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic we; logic re; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    logic stall; logic m_we; logic m_re; logic [AW-1:0] m_a; logic [DW-1:0] m_wd; logic [DW-1:0] rdata;
  } vec_t;
  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0011, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h1111, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h2222, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1111};
    vecs[5] = '{1'b0, 1'b1, 16'h0099, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0099, 16'h0000, 16'h5AC3};
    vecs[6] = '{1'b0, 1'b0, 16'h0099, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};

    // Reset held with a store presented: nothing is accepted or written.
    rst = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0777; cpu_wdata = 16'hDEAD;
    @(negedge clk); #1;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_mem_we", 32'(mem_WE), 32'd0);
    check("rst_mem_re", 32'(mem_RE), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("post_rst_count", 32'(dut.u_fifo.count_q), 32'd0);
    check("post_rst_mem_we", 32'(mem_WE), 32'd0);

    for (int i = 0; i < NV; i++) begin
      drive(1'b0, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      $display("vec%0d we=%0b re=%0b a=0x%0h stall=%0b mem_we=%0b mem_a=0x%0h rdata=0x%0h",
               i, vecs[i].we, vecs[i].re, vecs[i].addr, cpu_stall, mem_WE, mem_A, cpu_rdata);
      check($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].stall));
      check($sformatf("vec%0d_mem_we", i), 32'(mem_WE), 32'(vecs[i].m_we));
      check($sformatf("vec%0d_mem_re", i), 32'(mem_RE), 32'(vecs[i].m_re));
      check($sformatf("vec%0d_mem_a", i), 32'(mem_A), 32'(vecs[i].m_a));
      check($sformatf("vec%0d_mem_wd", i), 32'(mem_WD), 32'(vecs[i].m_wd));
      check($sformatf("vec%0d_rdata", i), 32'(cpu_rdata), 32'(vecs[i].rdata));
    end
    check("table_count", 32'(dut.u_fifo.count_q), 32'd0);

`ifdef STORE_BUFFER_FORWARD_EN
    // Youngest matching entry is forwarded; a miss reads memory.
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'hAAAA);
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'hBBBB);
    drive(1'b0, 1'b0, 1'b1, 16'h0020, '0);
    $display("fwd load 0x0020 stall=%0b rdata=0x%0h", cpu_stall, cpu_rdata);
    check("fwd_hit_rdata", 32'(cpu_rdata), 32'h0000BBBB);
    check("fwd_hit_stall", 32'(cpu_stall), 32'd0);
    check("fwd_hit_mem_re", 32'(mem_RE), 32'd1);
    check("fwd_hit_mem_we", 32'(mem_WE), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 16'h0021, '0);
    $display("fwd load 0x0021 rdata=0x%0h", cpu_rdata);
    check("fwd_miss_rdata", 32'(cpu_rdata), 32'h00005A7B);
    drain_all("fwd");

    // Load held to block drain: fills, stalls the 5th store, then store and drain coincide.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, AW'(16'h0100 + i), DW'(16'hC000 + i));
      check($sformatf("fill%0d_stall", i), 32'(cpu_stall), 32'd0);
    end
    drive(1'b0, 1'b1, 1'b1, 16'h0104, 16'hC004);
    $display("full store stall=%0b mem_we=%0b", cpu_stall, mem_WE);
    check("full_stall", 32'(cpu_stall), 32'd1);
    check("full_mem_we", 32'(mem_WE), 32'd0);
    check("full_count", 32'(dut.u_fifo.count_q), 32'(DEPTH));
    drive(1'b0, 1'b1, 1'b0, 16'h0104, 16'hC004);
    check("release_stall", 32'(cpu_stall), 32'd0);
    check("release_mem_we", 32'(mem_WE), 32'd1);
    check("release_mem_a", 32'(mem_A), 32'h0100);
    drive(1'b0, 1'b1, 1'b0, 16'h0105, 16'hC005);
    check("sixth_stall", 32'(cpu_stall), 32'd0);
    drain_all("full");
`else
    // Load waits for the buffer to empty, then reads the drained data from memory.
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'hAAAA);
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'hBBBB);
    drive(1'b0, 1'b0, 1'b1, 16'h0020, '0);
    $display("load 0x0020 stall=%0b mem_we=%0b", cpu_stall, mem_WE);
    check("ld_busy_stall", 32'(cpu_stall), 32'd1);
    check("ld_busy_mem_we", 32'(mem_WE), 32'd1);
    check("ld_busy_mem_re", 32'(mem_RE), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 16'h0020, '0);
    $display("load 0x0020 stall=%0b rdata=0x%0h", cpu_stall, cpu_rdata);
    check("ld_done_stall", 32'(cpu_stall), 32'd0);
    check("ld_done_mem_re", 32'(mem_RE), 32'd1);
    check("ld_done_rdata", 32'(cpu_rdata), 32'h0000BBBB);
    drain_all("ld");
`endif

    // Reset with entries buffered and a store pending discards everything.
    for (int i = 0; i < (FWD ? 3 : 2); i++)
      drive(1'b0, 1'b1, FWD, AW'(16'h0200 + i), DW'(16'hE000 + i));
    drive(1'b1, 1'b1, FWD, 16'h0203, 16'hE003);
    check("mid_rst_mem_we", 32'(mem_WE), 32'd0);
    check("mid_rst_mem_re", 32'(mem_RE), 32'd0);
    check("mid_rst_stall", 32'(cpu_stall), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    $display("after reset count=%0d mem_we=%0b", dut.u_fifo.count_q, mem_WE);
    check("mid_rst_count", 32'(dut.u_fifo.count_q), 32'd0);
    check("mid_rst_no_write", 32'(mem_WE), 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, '0, '0);

    // Push/drain across the pointer wrap with random idle gaps.
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if ($urandom_range(0, 2) == 0) drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b0, 1'b1, 1'b0, AW'(16'h0400 + i), DW'($urandom));
      check($sformatf("wrap%0d_stall", i), 32'(cpu_stall), 32'd0);
    end
    drain_all("wrap");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
